// File: rtl/axi4lite_wr_if_dma_pkg.sv
// Shared types and constants for the DMA AXI4-Lite write-channel front end.
package axi4lite_wr_if_dma_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;
    localparam int unsigned RESP_W     = 2;
    localparam int unsigned MEM_ADDR_W = 32;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [STRB_W-1:0] STRB_FULL = 4'hF;

    // Write-channel sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_W  = 3'd1,
        ST_WAIT_AW = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } wr_state_e;

    // Held W-channel beat
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_beat_t;

    // Partial-word writes are refused when strobe checking is enabled
    function automatic logic beat_rejected(input logic check_en, input logic [STRB_W-1:0] strb);
        return check_en && (strb != STRB_FULL);
    endfunction

endpackage

// File: rtl/axi4lite_wr_if_dma.sv
// AXI4-Lite slave write-channel front end for the DMA register block.
// Accepts AW and W independently, pairs them, emits a single-cycle register
// write strobe, then returns the B response. One transaction outstanding.
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   s_axi_aw*                write address channel (valid/ready/addr)
//   s_axi_w*                 write data channel (valid/ready/data/strb)
//   s_axi_b*                 write response channel (valid/ready/resp)
//   mem_wr_valid/addr/data   one-cycle write strobe to the register decoder
module axi4lite_wr_if_dma
    import axi4lite_wr_if_dma_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter bit          CHECK_WSTRB    = 1'b1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [DATA_W-1:0]         s_axi_wdata,
    input  logic [STRB_W-1:0]         s_axi_wstrb,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [RESP_W-1:0]         s_axi_bresp,
    output logic                      mem_wr_valid,
    output logic [MEM_ADDR_W-1:0]     mem_wr_addr,
    output logic [DATA_W-1:0]         mem_wr_data
);

    wr_state_e                 state_q, state_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [RESP_W-1:0]         bresp_q, bresp_d;
    logic                      mem_valid_q, mem_valid_d;
    logic [MEM_ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]         mem_data_q, mem_data_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    wr_beat_t                  beat_q, beat_d;
    logic                      aw_hs, w_hs, b_hs;

    // State, holding and output registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= AXI_RESP_OKAY;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        bresp_d     = bresp_q;
        mem_valid_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        addr_d      = addr_q;
        beat_d      = beat_q;

        // Handshakes use the registered readies, so outputs never depend combinationally on inputs
        aw_hs = s_axi_awvalid && awready_q;
        w_hs  = s_axi_wvalid && wready_q;
        b_hs  = bvalid_q && s_axi_bready;

        if (aw_hs) begin
            addr_d = s_axi_awaddr;
        end
        if (w_hs) begin
            beat_d = '{data: s_axi_wdata, strb: s_axi_wstrb};
        end

        case (state_q)
            ST_IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d = ST_WRITE;
                end else if (aw_hs) begin
                    state_d = ST_WAIT_W;
                end else if (w_hs) begin
                    state_d = ST_WAIT_AW;
                end
            end
            ST_WAIT_W: begin
                if (w_hs) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT_AW: begin
                if (aw_hs) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        awready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_AW);
        wready_d  = (state_d == ST_IDLE) || (state_d == ST_WAIT_W);
        bvalid_d  = (state_d == ST_RESP);

        // Strobe is launched on entry to WRITE; addr_d/beat_d already include a same-edge capture
        if ((state_d == ST_WRITE) && !beat_rejected(CHECK_WSTRB, beat_d.strb)) begin
            mem_valid_d = 1'b1;
            mem_addr_d  = MEM_ADDR_W'(addr_d);
            mem_data_d  = beat_d.data;
        end

        if (state_q == ST_WRITE) begin
            bresp_d = beat_rejected(CHECK_WSTRB, beat_q.strb) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign mem_wr_valid  = mem_valid_q;
    assign mem_wr_addr   = mem_addr_q;
    assign mem_wr_data   = mem_data_q;

endmodule

// File: tb/tb_axi4lite_wr_if_dma.sv
// Bench for axi4lite_wr_if_dma: two instances (strobe check off / on) share stimulus
// and are compared every cycle against a transaction-level model.
module tb_axi4lite_wr_if_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bready;

    logic [1:0]  awready, wready, bvalid, mem_valid;
    logic [1:0]  bresp    [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_data [2];

    int n_vec = 0;
    int n_err = 0;
    int n_dut_strobes = 0;

    always #5 clk = ~clk;

    axi4lite_wr_if_dma #(.AXI_ADDR_WIDTH(32), .CHECK_WSTRB(1'b0)) u_dut_nochk (
        .aclk(clk), .areset(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready[0]), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready[0]), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready), .s_axi_bresp(bresp[0]),
        .mem_wr_valid(mem_valid[0]), .mem_wr_addr(mem_addr[0]), .mem_wr_data(mem_data[0])
    );

    axi4lite_wr_if_dma #(.AXI_ADDR_WIDTH(32), .CHECK_WSTRB(1'b1)) u_dut_chk (
        .aclk(clk), .areset(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready[1]), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready[1]), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready), .s_axi_bresp(bresp[1]),
        .mem_wr_valid(mem_valid[1]), .mem_wr_addr(mem_addr[1]), .mem_wr_data(mem_data[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        m_awready, m_wready, m_bvalid;
    logic        m_mem_valid [2];
    logic [1:0]  m_bresp     [2];
    logic [1:0]  m_bresp_pend[2];
    logic [31:0] m_addr      [2];
    logic [31:0] m_data      [2];
    logic        have_aw, have_w, in_write, aw_fired, w_fired;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_strb;
    int          m_strobes = 0;

    task automatic model_reset();
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        have_aw = 1'b0; have_w = 1'b0; in_write = 1'b0;
        aw_fired = 1'b0; w_fired = 1'b0;
        h_addr = '0; h_data = '0; h_strb = '0;
        for (int k = 0; k < 2; k++) begin
            m_mem_valid[k] = 1'b0; m_bresp[k] = 2'b00; m_bresp_pend[k] = 2'b00;
            m_addr[k] = '0; m_data[k] = '0;
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            aw_fired = awvalid && m_awready;
            w_fired  = wvalid && m_wready;
            if (aw_fired) begin h_addr = awaddr; have_aw = 1'b1; end
            if (w_fired)  begin h_data = wdata; h_strb = wstrb; have_w = 1'b1; end
            for (int k = 0; k < 2; k++) m_mem_valid[k] = 1'b0;
            if (in_write) begin
                // response follows the strobe cycle
                in_write = 1'b0;
                m_bvalid = 1'b1;
                for (int k = 0; k < 2; k++) m_bresp[k] = m_bresp_pend[k];
            end else if (have_aw && have_w) begin
                in_write = 1'b1;
                have_aw = 1'b0;
                have_w  = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    if (k == 1 && h_strb != 4'hF) begin
                        m_bresp_pend[k] = 2'b10;
                    end else begin
                        m_bresp_pend[k] = 2'b00;
                        m_mem_valid[k]  = 1'b1;
                        m_addr[k]       = h_addr;
                        m_data[k]       = h_data;
                        if (k == 1) m_strobes++;
                    end
                end
            end else if (m_bvalid && bready) begin
                m_bvalid = 1'b0;
            end
            // one outstanding: a channel is ready only if idle and not already holding its half
            m_awready = !(in_write || m_bvalid) && !have_aw;
            m_wready  = !(in_write || m_bvalid) && !have_w;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("awready%0d", k),   32'(awready[k]),   32'(m_awready));
            check($sformatf("wready%0d", k),    32'(wready[k]),    32'(m_wready));
            check($sformatf("bvalid%0d", k),    32'(bvalid[k]),    32'(m_bvalid));
            check($sformatf("bresp%0d", k),     32'(bresp[k]),     32'(m_bresp[k]));
            check($sformatf("mem_valid%0d", k), 32'(mem_valid[k]), 32'(m_mem_valid[k]));
            check($sformatf("mem_addr%0d", k),  mem_addr[k],       m_addr[k]);
            check($sformatf("mem_data%0d", k),  mem_data[k],       m_data[k]);
        end
        if (mem_valid[1]) n_dut_strobes++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_awready", 32'(awready[1]), 32'h0);
        check("reset_bvalid", 32'(bvalid[1]), 32'h0);
        rst = 1'b0;
        step();
        check("ready_after_release", 32'({awready[1], wready[1]}), 32'h3);

        // simultaneous AW and W
        awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; awaddr = 32'hFFFF_FFFF; wdata = '0;
        check("t1_strobe", 32'(mem_valid[1]), 32'h1);
        check("t1_addr", mem_addr[1], 32'h10);
        check("t1_data", mem_data[1], 32'hDEAD_BEEF);
        check("t1_ready_low", 32'({awready[1], wready[1]}), 32'h0);
        step();
        check("t1_strobe_once", 32'(mem_valid[1]), 32'h0);
        check("t1_bvalid", 32'(bvalid[1]), 32'h1);
        check("t1_bresp", 32'(bresp[1]), 32'h0);
        step();
        check("t1_bdone", 32'({bvalid[1], awready[1]}), 32'h1);

        // W first, AW five cycles later
        wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF;
        step();
        wvalid = 1'b0; wdata = 32'h0BAD_0BAD;
        check("t2_wready_low", 32'(wready[1]), 32'h0);
        check("t2_awready_hi", 32'(awready[1]), 32'h1);
        repeat (4) begin
            step();
            check("t2_wready_hold", 32'(wready[1]), 32'h0);
        end
        awvalid = 1'b1; awaddr = 32'h24;
        step();
        awvalid = 1'b0;
        check("t2_strobe", 32'(mem_valid[1]), 32'h1);
        check("t2_addr", mem_addr[1], 32'h24);
        check("t2_data", mem_data[1], 32'h1234_5678);
        step(); step();

        // B backpressure with a second AW waiting
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 32'h30; wvalid = 1'b1; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        step();
        wvalid = 1'b0; awaddr = 32'h34;
        step();
        check("t3_bvalid", 32'(bvalid[1]), 32'h1);
        repeat (10) begin
            step();
            check("t3_bvalid_hold", 32'(bvalid[1]), 32'h1);
            check("t3_ready_hold", 32'({awready[1], wready[1]}), 32'h0);
        end
        bready = 1'b1;
        step();
        check("t3_b_release", 32'({bvalid[1], awready[1]}), 32'h1);
        step();
        awvalid = 1'b0;
        check("t3_second_aw", 32'({awready[1], wready[1]}), 32'h1);
        wvalid = 1'b1; wdata = 32'hA5A5_0002;
        step();
        wvalid = 1'b0;
        check("t3_addr2", mem_addr[1], 32'h34);
        check("t3_strobe2", 32'(mem_valid[1]), 32'h1);
        step(); step();

        // partial strobe: rejected only when checking is enabled
        awvalid = 1'b1; awaddr = 32'h44; wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'h3;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t4_chk_no_strobe", 32'(mem_valid[1]), 32'h0);
        check("t4_chk_addr_held", mem_addr[1], 32'h34);
        check("t4_nochk_strobe", 32'(mem_valid[0]), 32'h1);
        step();
        check("t4_chk_slverr", 32'(bresp[1]), 32'h2);
        check("t4_nochk_okay", 32'(bresp[0]), 32'h0);
        step();

        // reset while waiting for W
        wstrb = 4'hF;
        awvalid = 1'b1; awaddr = 32'h50;
        step();
        awvalid = 1'b0; awaddr = 32'h99;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_outputs", 32'({awready[1], wready[1], bvalid[1], bresp[1], mem_valid[1]}), 32'h0);
        check("t5_rst_addr", mem_addr[1], 32'h0);
        check("t5_rst_data", mem_data[1], 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        awvalid = 1'b1; awaddr = 32'h60; wvalid = 1'b1; wdata = 32'h600D_0006;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t5_fresh_addr", mem_addr[1], 32'h60);
        check("t5_fresh_strobe", 32'(mem_valid[1]), 32'h1);
        step(); step();

        // randomized traffic with valid/ready gaps
        for (int c = 0; c < 1500; c++) begin
            step();
            if (!awvalid || aw_fired) begin
                awvalid = ($urandom_range(0, 2) == 0);
                awaddr  = $urandom;
            end
            if (!wvalid || w_fired) begin
                wvalid = ($urandom_range(0, 2) == 0);
                wdata  = $urandom;
                wstrb  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end
            bready = ($urandom_range(0, 1) == 1);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        repeat (8) step();
        check("strobe_count", 32'(n_dut_strobes), 32'(m_strobes));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
